// File: rtl/car_lane_ctrl.sv
// One Frogger road lane: car positions, per-frame movement with edge wrap,
// a two-stage pixel pipeline into the shared car sprite ROM, and a sticky frog hit flag.
module car_lane_ctrl #(
    parameter int NUM_CARS  = 3,
    parameter int SPRITE    = 24,
    parameter int SCREEN_W  = 640,
    parameter int SPACING   = 213,
    parameter int SPEED_DIV = 2,
    parameter int STEP      = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       enable,
    input  logic       dir,
    input  logic [9:0] lane_y,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [7:0] rom_data,
    input  logic [9:0] frog_x,
    input  logic [9:0] frog_y,
    input  logic       clear_hit,
    output logic [5:0] DX,
    output logic [5:0] DY,
    output logic       car_on,
    output logic [7:0] color_idx,
    output logic       hit,
    output logic       frame_tick
);

    localparam int XW    = 11;
    localparam int CW    = 12;
    localparam int DIV_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;

    localparam logic signed [XW-1:0] STEP_S  = XW'(STEP);
    localparam logic signed [XW-1:0] LWRAP_S = XW'(-SPRITE);
    localparam logic signed [XW-1:0] RWRAP_S = XW'(SCREEN_W);
    localparam logic signed [XW-1:0] SPAN_S  = XW'(SCREEN_W + SPRITE);
    localparam logic signed [CW-1:0] SPR_C   = CW'(SPRITE);
    localparam logic signed [CW-1:0] ZERO_C  = '0;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SPEED_DIV - 1);
    localparam logic [DIV_W-1:0]     DIV_ONE  = DIV_W'(1);
    localparam logic [5:0]           MIRROR   = 6'(SPRITE - 1);

    // One movement step including the wrap, so a car never sits off-range for a cycle.
    function automatic logic signed [XW-1:0] step_x(input logic signed [XW-1:0] x,
                                                    input logic right);
        logic signed [XW-1:0] nx;
        if (right) begin
            nx = x + STEP_S;
            if (nx >= RWRAP_S) nx = nx - SPAN_S;
        end else begin
            nx = x - STEP_S;
            if (nx <= LWRAP_S) nx = nx + SPAN_S;
        end
        return nx;
    endfunction

    function automatic logic signed [CW-1:0] sx(input logic signed [XW-1:0] v);
        return CW'(v);
    endfunction

    function automatic logic signed [CW-1:0] ux(input logic [9:0] v);
        return $signed({2'b00, v});
    endfunction

    // 1-D intersection of [a, a+SPRITE) and [b, b+SPRITE).
    function automatic logic span_hit(input logic signed [CW-1:0] a,
                                      input logic signed [CW-1:0] b);
        return (a < b + SPR_C) && (b < a + SPR_C);
    endfunction

    logic                    fc_s1, fc_s2, fc_s3;
    logic [DIV_W-1:0]        div;
    logic signed [XW-1:0]    car_x [NUM_CARS];
    logic                    frog_ov;
    logic                    pix_cov;
    logic [5:0]              pix_off;
    logic signed [CW-1:0]    dx_rel;
    logic signed [CW-1:0]    dy_rel;
    logic                    in_y;
    logic [5:0]              dx_p1, dy_p1;
    logic                    cov_p1;
    logic                    car_on_p2;
    logic [7:0]              color_p2;

    // frame_clk synchronizer and rising-edge pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_s1      <= 1'b0;
            fc_s2      <= 1'b0;
            fc_s3      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            fc_s1      <= frame_clk;
            fc_s2      <= fc_s1;
            fc_s3      <= fc_s2;
            frame_tick <= fc_s2 & ~fc_s3;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div <= '0;
            for (int i = 0; i < NUM_CARS; i++) car_x[i] <= XW'(i * SPACING);
        end else if (frame_tick && enable) begin
            if (div == DIV_LAST) begin
                div <= '0;
                for (int i = 0; i < NUM_CARS; i++) car_x[i] <= step_x(car_x[i], dir);
            end else begin
                div <= div + DIV_ONE;
            end
        end
    end

    // Collision sees the pre-step positions because car_x updates on the same edge.
    always_comb begin
        frog_ov = 1'b0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (span_hit(sx(car_x[i]), ux(frog_x)) && span_hit(ux(lane_y), ux(frog_y)))
                frog_ov = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            hit <= 1'b0;
        else if (frame_tick && frog_ov)
            hit <= 1'b1;
        else if (clear_hit)
            hit <= 1'b0;
    end

    // Walk from the highest index down so the lowest covering car is the one kept.
    always_comb begin
        pix_cov = 1'b0;
        pix_off = '0;
        dx_rel  = '0;
        dy_rel  = ux(DrawY) - ux(lane_y);
        in_y    = (dy_rel >= ZERO_C) && (dy_rel < SPR_C);
        for (int i = NUM_CARS - 1; i >= 0; i--) begin
            dx_rel = ux(DrawX) - sx(car_x[i]);
            if (in_y && (dx_rel >= ZERO_C) && (dx_rel < SPR_C)) begin
                pix_cov = 1'b1;
                pix_off = dx_rel[5:0];
            end
        end
    end

    // stage 1: sprite address
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dx_p1  <= '0;
            dy_p1  <= '0;
            cov_p1 <= 1'b0;
        end else begin
            cov_p1 <= pix_cov;
            if (pix_cov) begin
                dx_p1 <= dir ? (MIRROR - pix_off) : pix_off;
                dy_p1 <= dy_rel[5:0];
            end else begin
                dx_p1 <= '0;
                dy_p1 <= '0;
            end
        end
    end

    // stage 2: qualify ROM palette index
    always_ff @(posedge Clk) begin
        if (Reset) begin
            car_on_p2 <= 1'b0;
            color_p2  <= '0;
        end else begin
            car_on_p2 <= cov_p1 && (rom_data != 8'd0);
            color_p2  <= cov_p1 ? rom_data : 8'd0;
        end
    end

    assign DX        = dx_p1;
    assign DY        = dy_p1;
    assign car_on    = car_on_p2;
    assign color_idx = color_p2;

endmodule

// File: tb/tb_car_lane_ctrl.sv
// Directed bench for car_lane_ctrl: movement, wrap, pixel pipeline, priority and hit flag.
module tb_car_lane_ctrl;

    logic       Clk = 1'b0;
    logic       Reset, frame_clk, enable, enable2, dir, clear_hit;
    logic [9:0] lane_y, DrawX, DrawY, frog_x, frog_y;
    logic [7:0] rom_data;
    logic [5:0] DX, DY, DX2, DY2;
    logic       car_on, car_on2, hit, hit2, frame_tick, frame_tick2;
    logic [7:0] color_idx, color_idx2;

    int n_checks = 0;
    int n_errs   = 0;

    logic [5:0] p_dx, p_dy, p2_dx;
    logic       p_on, p2_on;
    logic [7:0] p_col;
    int         lat, wid;
    int         exp_a [4] = '{5, 7, 7, 9};

    always #5 Clk = ~Clk;

    car_lane_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable), .dir(dir),
        .lane_y(lane_y), .DrawX(DrawX), .DrawY(DrawY), .rom_data(rom_data),
        .frog_x(frog_x), .frog_y(frog_y), .clear_hit(clear_hit),
        .DX(DX), .DY(DY), .car_on(car_on), .color_idx(color_idx),
        .hit(hit), .frame_tick(frame_tick)
    );

    // Cars at 0, 10, 20 overlap each other, exercising the lowest-index priority.
    car_lane_ctrl #(.SPACING(10)) dut2 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable2), .dir(dir),
        .lane_y(lane_y), .DrawX(DrawX), .DrawY(DrawY), .rom_data(rom_data),
        .frog_x(10'd0), .frog_y(10'd0), .clear_hit(1'b0),
        .DX(DX2), .DY(DY2), .car_on(car_on2), .color_idx(color_idx2),
        .hit(hit2), .frame_tick(frame_tick2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic probe(input int x, input int y, input int rom);
        @(negedge Clk);
        DrawX    = 10'(x);
        DrawY    = 10'(y);
        rom_data = 8'(rom);
        @(negedge Clk);
        p_dx  = DX;
        p_dy  = DY;
        p2_dx = DX2;
        @(negedge Clk);
        p_on  = car_on;
        p_col = color_idx;
        p2_on = car_on2;
    endtask

    task automatic frame_pulse(input bit clr_on_tick, output int l, output int w);
        l = -1;
        w = 0;
        @(negedge Clk);
        frame_clk = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge Clk);
            if (frame_tick) begin
                l = i;
                break;
            end
        end
        if (l > 0) begin
            w = 1;
            if (clr_on_tick) clear_hit = 1'b1;
            for (int i = 0; i < 8; i++) begin
                @(negedge Clk);
                clear_hit = 1'b0;
                if (!frame_tick) break;
                w++;
            end
        end
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic pulses(input int n);
        int l, w;
        for (int k = 0; k < n; k++) begin
            frame_pulse(1'b0, l, w);
            if (l < 0) chk("tick_timeout", 32'(l), 32'd3);
        end
    endtask

    task automatic clear_pulse();
        @(negedge Clk);
        clear_hit = 1'b1;
        @(negedge Clk);
        clear_hit = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; enable = 1'b0; enable2 = 1'b0; dir = 1'b0;
        clear_hit = 1'b0; lane_y = 10'd200; frog_x = 10'd0; frog_y = 10'd0;
        DrawX = 10'd5; DrawY = 10'd203; rom_data = 8'd9;
        repeat (3) @(negedge Clk);
        chk("rst_dx", DX, 0);
        chk("rst_dy", DY, 0);
        chk("rst_car_on", car_on, 0);
        chk("rst_color", color_idx, 0);
        chk("rst_hit", hit, 0);
        chk("rst_tick", frame_tick, 0);
        Reset = 1'b0;

        probe(5, 200, 0);   chk("init_x0", p_dx, 5);
        probe(218, 201, 0); chk("init_x1", p_dx, 5); chk("init_x1_dy", p_dy, 1);
        probe(430, 202, 0); chk("init_x2", p_dx, 4);

        probe(15, 205, 5);  chk("prio_c0", p2_dx, 15); chk("prio_on", p2_on, 1);
        probe(25, 205, 5);  chk("prio_c1", p2_dx, 15);
        probe(40, 205, 5);  chk("prio_c2", p2_dx, 20);
        dir = 1'b1;
        probe(15, 205, 5);  chk("prio_mirror", p2_dx, 8);
        dir = 1'b0;

        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            frame_pulse(1'b0, lat, wid);
            chk("tick_latency", 32'(lat), 3);
            chk("tick_width", 32'(wid), 1);
            probe(5, 200, 0);
            chk("step_left_x0", p_dx, 32'(exp_a[k]));
        end

        pulses(18);
        probe(0, 210, 0);  chk("x0_m22", p_dx, 22); chk("x0_m22_dy", p_dy, 10);
        probe(1, 210, 4);  chk("x0_m22_edge", p_dx, 23); chk("x0_m22_on", p_on, 1);
        probe(2, 210, 4);  chk("x0_m22_out", p_dx, 0); chk("x0_m22_out_on", p_on, 0);
        pulses(2);
        probe(645, 200, 0); chk("wrap_left", p_dx, 5);
        pulses(2);
        probe(640, 200, 0); chk("x0_638", p_dx, 2);
        dir = 1'b1;
        probe(640, 200, 0); chk("dir_no_move", p_dx, 21);
        pulses(2);
        probe(645, 200, 7); chk("wrap_right_old", p_dx, 0); chk("wrap_right_on", p_on, 0);
        pulses(2);
        probe(0, 200, 0);   chk("wrap_right_new", p_dx, 1);

        pulses(122);
        dir = 1'b0;
        probe(105, 203, 0);
        chk("pix_dx", p_dx, 5); chk("pix_dy", p_dy, 3);
        chk("pix_rom0_on", p_on, 0); chk("pix_rom0_col", p_col, 0);
        probe(112, 207, 24);
        chk("pix2_dx", p_dx, 12); chk("pix2_dy", p_dy, 7);
        chk("pix2_on", p_on, 1); chk("pix2_col", p_col, 24);
        dir = 1'b1;
        probe(105, 203, 24); chk("pix_mirror", p_dx, 18);
        dir = 1'b0;
        probe(50, 203, 55);
        chk("out_dx", p_dx, 0); chk("out_dy", p_dy, 0);
        chk("out_on", p_on, 0); chk("out_col", p_col, 0);
        probe(123, 223, 1); chk("corner_dx", p_dx, 23); chk("corner_dy", p_dy, 23);
        chk("corner_on", p_on, 1);
        probe(124, 203, 1); chk("right_edge_on", p_on, 0);
        probe(110, 224, 1); chk("bottom_edge_on", p_on, 0);
        probe(110, 199, 1); chk("top_edge_on", p_on, 0);
        probe(320, 205, 3); chk("car1_dx", p_dx, 7); chk("car1_col", p_col, 3);
        probe(530, 200, 3); chk("car2_dx", p_dx, 4);

        // back-to-back pixels
        @(negedge Clk); DrawX = 10'd105; DrawY = 10'd203; rom_data = 8'd0;
        @(negedge Clk); chk("bb_dx_a", DX, 5);
        DrawX = 10'd112; DrawY = 10'd207; rom_data = 8'd0;
        @(negedge Clk); chk("bb_dx_b", DX, 12); chk("bb_on_a", car_on, 0);
        rom_data = 8'd24;
        @(negedge Clk); chk("bb_on_b", car_on, 1); chk("bb_col_b", color_idx, 24);

        enable = 1'b0;
        chk("hit_idle", hit, 0);
        frog_x = 10'd110; frog_y = 10'd210;
        pulses(1); chk("hit_set", hit, 1);
        frog_y = 10'd0;
        pulses(1); chk("hit_sticky", hit, 1);
        clear_pulse(); chk("hit_clear", hit, 0);
        frog_y = 10'd210;
        frame_pulse(1'b1, lat, wid); chk("hit_set_wins", hit, 1);
        clear_pulse(); chk("hit_clear2", hit, 0);
        frog_x = 10'd124; frog_y = 10'd210;
        pulses(1); chk("hit_x_edge", hit, 0);
        frog_x = 10'd100; frog_y = 10'd224;
        pulses(1); chk("hit_y_edge", hit, 0);
        frog_x = 10'd77; frog_y = 10'd200;
        pulses(1); chk("hit_left_touch", hit, 1);
        clear_pulse();
        frog_x = 10'd0; frog_y = 10'd0;
        pulses(1);
        probe(105, 203, 0); chk("frozen_x0", p_dx, 5);
        enable = 1'b1;
        pulses(1);
        probe(105, 203, 0); chk("div_held", p_dx, 5);
        pulses(1);
        probe(105, 203, 0); chk("div_step", p_dx, 7);

        frog_x = 10'd110; frog_y = 10'd210;
        pulses(1); chk("hit_pre_rst", hit, 1);
        @(negedge Clk); DrawX = 10'd105; DrawY = 10'd203; rom_data = 8'd9;
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_dx", DX, 0); chk("midrst_dy", DY, 0);
        chk("midrst_on", car_on, 0); chk("midrst_col", color_idx, 0);
        chk("midrst_hit", hit, 0);
        Reset = 1'b0; frog_x = 10'd0; frog_y = 10'd0;
        probe(5, 200, 0); chk("midrst_x0", p_dx, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
